mem_stage_ctrl: RTL

- MEM stage of the 5-stage pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs.
- Runs a request/acknowledge data-memory access (multi-cycle memory allowed) and stalls upstream while the access is outstanding.
- Resolves branch/jump redirect to the fetch stage.
- Contains the MEM/WB pipeline register feeding writeback.

---
 rtl/mem_stage_ctrl_pkg.sv | 17 +
 rtl/mem_stage_ctrl_mem_wb.sv | 45 ++++
 rtl/mem_stage_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the MEM stage: FSM encoding, writeback select codes
// and the default memory-timeout length.
package mem_stage_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC4 = 2'd2;

  localparam int TIMEOUT_DEF = 16;

endpackage

// File: rtl/mem_stage_ctrl_mem_wb.sv
// MEM/WB pipeline register. A bubble kills the write but leaves the data
// fields holding their last values.
module mem_wb_reg #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic         bubble_i,
  input  logic [N-1:0] read_data_i,
  input  logic [N-1:0] alu_result_i,
  input  logic [N-1:0] pc_plus4_i,
  input  logic [4:0]   write_register_i,
  input  logic [1:0]   memtoreg_i,
  input  logic         regwrite_i,
  output logic [N-1:0] read_data_o,
  output logic [N-1:0] alu_result_o,
  output logic [N-1:0] pc_plus4_o,
  output logic [4:0]   write_register_o,
  output logic [1:0]   memtoreg_o,
  output logic         regwrite_o
);

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      read_data_o      <= '0;
      alu_result_o     <= '0;
      pc_plus4_o       <= '0;
      write_register_o <= '0;
      memtoreg_o       <= '0;
      regwrite_o       <= 1'b0;
    end else if (bubble_i) begin
      write_register_o <= '0;
      regwrite_o       <= 1'b0;
    end else if (load_i) begin
      read_data_o      <= read_data_i;
      alu_result_o     <= alu_result_i;
      pc_plus4_o       <= pc_plus4_i;
      write_register_o <= write_register_i;
      memtoreg_o       <= memtoreg_i;
      regwrite_o       <= regwrite_i;
    end
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM stage: request/acknowledge data-memory access with upstream stall and
// timeout, branch/jump redirect, and the MEM/WB register.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int N       = 32,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = $clog2(TIMEOUT) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] alu_result_i,
  input  logic [N-1:0] read_data2_i,
  input  logic [N-1:0] pc_plus_imm_i,
  input  logic [N-1:0] pc_plus4_i,
  input  logic [4:0]   write_register_i,
  input  logic [1:0]   memtoreg_i,
  input  logic         regwrite_i,
  input  logic         branch_i,
  input  logic         zero_i,
  input  logic         jal_i,
  input  logic         memwrite_i,
  input  logic         memread_i,
  output logic         dmem_req_o,
  output logic         dmem_we_o,
  output logic [N-1:0] dmem_addr_o,
  output logic [N-1:0] dmem_wdata_o,
  input  logic         dmem_ack_i,
  input  logic [N-1:0] dmem_rdata_i,
  output logic         stall_o,
  output logic         pcsrc_o,
  output logic [N-1:0] branch_target_o,
  output logic         mem_err_o,
  output logic [N-1:0] read_data_o,
  output logic [N-1:0] alu_result_o,
  output logic [N-1:0] pc_plus4_o,
  output logic [4:0]   write_register_o,
  output logic [1:0]   memtoreg_o,
  output logic         regwrite_o,
  output logic [1:0]   state_o
);

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [N-1:0]       data_q;
  logic               mem_op;
  logic               wb_load;
  logic               wb_bubble;
  logic [N-1:0]       wb_rdata;

  assign mem_op  = memread_i | memwrite_i;
  assign state_o = state_q;

  always_comb begin
    stall_o = 1'b0;
    case (state_q)
      ST_IDLE: stall_o = mem_op;
      ST_BUSY: stall_o = 1'b1;
      default: stall_o = 1'b0;
    endcase
  end

  // Redirect is suppressed while stalled so fetch does not act on a held branch twice.
  assign pcsrc_o         = ((branch_i & zero_i) | jal_i) & ~stall_o;
  assign branch_target_o = pc_plus_imm_i;

  assign wb_load   = ((state_q == ST_IDLE) && !mem_op) || (state_q == ST_DONE);
  assign wb_bubble = !wb_load;
  assign wb_rdata  = (state_q == ST_DONE) ? data_q : '0;

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      data_q       <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      mem_err_o    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (mem_op) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= memwrite_i;
            dmem_addr_o  <= alu_result_i;
            dmem_wdata_o <= read_data2_i;
            cnt_q        <= '0;
            state_q      <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // Ack takes priority over an expiring counter on the same edge.
          if (dmem_ack_i) begin
            data_q     <= dmem_we_o ? '0 : dmem_rdata_i;
            dmem_req_o <= 1'b0;
            state_q    <= ST_DONE;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            mem_err_o  <= 1'b1;
            data_q     <= '0;
            dmem_req_o <= 1'b0;
            state_q    <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mem_wb_reg #(.N(N)) u_mem_wb (
    .clk              (clk),
    .reset            (reset),
    .load_i           (wb_load),
    .bubble_i         (wb_bubble),
    .read_data_i      (wb_rdata),
    .alu_result_i     (alu_result_i),
    .pc_plus4_i       (pc_plus4_i),
    .write_register_i (write_register_i),
    .memtoreg_i       (memtoreg_i),
    .regwrite_i       (regwrite_i),
    .read_data_o      (read_data_o),
    .alu_result_o     (alu_result_o),
    .pc_plus4_o       (pc_plus4_o),
    .write_register_o (write_register_o),
    .memtoreg_o       (memtoreg_o),
    .regwrite_o       (regwrite_o)
  );

endmodule
